// File: rtl/mem_requester.sv
// Core-side initiator for one MemController slot: turns a single write or a 1-15 word read
//   burst into held rden/wren + address levels, returns read words and flags completion/timeout.
// Latency: at least REQ(acq) + RDATA per read word and REQ(acq) + DONE per write. rd_valid
//   appears in the cycle after RDATA, and done appears in the cycle after DONE.
// Backpressure: req_ready is high only in IDLE, and req_valid is ignored while busy. Each word
//   waits in REQ for mem_acq, and is aborted after TIMEOUT grantless cycles if TIMEOUT != 0.
//
// Ports:
//   CLK, rst                          clock and synchronous active-high reset
//   req_valid/ready, req_write,       request handshake: write flag, start address,
//   req_addr, req_wdata, req_len      write data and read length (0 means 1 word)
//   rd_valid, rd_data                 read word pulse; rd_data holds until the next word
//   done, err, busy                   completion pulse, timeout flag (with done), activity
//   mem_rden/wren/addr/din            request levels to the MemController slot
//   mem_dq, mem_acq                   RAM read data and slot grant
module mem_requester #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          req_valid,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [3:0]    req_len,
  output logic          req_ready,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          done,
  output logic          err,
  output logic          busy,
  output logic          mem_rden,
  output logic          mem_wren,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dq,
  input  logic          mem_acq
);

  // tcnt only has to count up to TIMEOUT-1.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RDATA, S_DONE} state_t;

  state_t          state;
  logic            write_q;
  logic [AW-1:0]   cur_addr;
  logic [DW-1:0]   wdata_q;
  logic [3:0]      cnt;
  logic [TW-1:0]   tcnt;
  logic            err_flag;

  // Every output is a register or a decode of the state register, so there is no
  // combinational path from mem_acq or mem_dq to any output.
  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign mem_addr  = cur_addr;
  assign mem_din   = wdata_q;

  always_ff @(posedge CLK) begin
    if (rst) begin
      state    <= S_IDLE;
      write_q  <= 1'b0;
      cur_addr <= '0;
      wdata_q  <= '0;
      cnt      <= 4'd0;
      tcnt     <= '0;
      err_flag <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      mem_rden <= 1'b0;
      mem_wren <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            cur_addr <= req_addr;
            wdata_q  <= req_wdata;
            cnt      <= (req_len == 4'd0) ? 4'd1 : req_len;
            tcnt     <= '0;
            mem_rden <= !req_write;
            mem_wren <= req_write;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          // A grant takes priority over the timeout in the same cycle.
          if (mem_acq) begin
            mem_rden <= 1'b0;
            mem_wren <= 1'b0;
            state    <= write_q ? S_DONE : S_RDATA;
          end else if (TIMEOUT != 0 && tcnt == TCNT_LAST) begin
            err_flag <= 1'b1;
            mem_rden <= 1'b0;
            mem_wren <= 1'b0;
            state    <= S_DONE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_RDATA: begin
          // The RAM presents q one cycle after the granted cycle, which is this cycle.
          rd_data  <= mem_dq;
          rd_valid <= 1'b1;
          cur_addr <= cur_addr + AW'(1);
          cnt      <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= S_DONE;
          end else begin
            tcnt     <= '0;
            mem_rden <= 1'b1;
            state    <= S_REQ;
          end
        end
        S_DONE: begin
          // done is registered out of DONE, so it lands one cycle after the last rd_valid.
          done     <= 1'b1;
          err      <= err_flag;
          err_flag <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_requester.sv
module tb_mem_requester;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 4;

  logic          CLK = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [3:0]    req_len = '0;
  logic          req_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          done;
  logic          err;
  logic          busy;
  logic          mem_rden;
  logic          mem_wren;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dq = '0;
  logic          mem_acq = 1'b0;

  mem_requester #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_len(req_len), .req_ready(req_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err), .busy(busy),
    .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dq(mem_dq), .mem_acq(mem_acq)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit         is_done;
    logic [7:0] data;
    bit         err;
  } exp_t;

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] din;
  } grant_t;

  exp_t   exp_q[$];     // expected rd_valid / done events, in order
  int     delay_q[$];   // grant delay per REQ episode, consumed by the slot model
  grant_t grant_q[$];   // log of granted accesses
  logic [7:0] ram[256];     // RAM behind the slot
  logic [7:0] ram_m[256];   // reference model's view of memory

  int rden_cycles = 0, wren_cycles = 0, rdv_cnt = 0, done_cnt = 0, cyc = 0;
  int last_rdv_cyc = 0, last_done_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic int rand_delay();
    return ($urandom_range(0, 9) == 0) ? 6 : int'($urandom_range(0, 3));
  endfunction

  // Monitor / scoreboard.
  always @(negedge CLK) begin
    cyc++;
    if (!rst) begin
      if (mem_rden) rden_cycles++;
      if (mem_wren) wren_cycles++;
      check("rdv_done_exclusive", {31'd0, rd_valid & done}, 32'd0);
      check("err_needs_done", {31'd0, err & !done}, 32'd0);
      if (rd_valid) begin
        exp_t e;
        rdv_cnt++;
        last_rdv_cyc = cyc;
        if (exp_q.size() == 0) fail("unexpected_rd_valid");
        else begin
          e = exp_q.pop_front();
          check("rd_is_word", {31'd0, e.is_done}, 32'd0);
          check("rd_data", {24'd0, rd_data}, {24'd0, e.data});
        end
      end
      if (done) begin
        exp_t e;
        done_cnt++;
        last_done_cyc = cyc;
        if (exp_q.size() == 0) fail("unexpected_done");
        else begin
          e = exp_q.pop_front();
          check("done_is_end", {31'd0, e.is_done}, 32'd1);
          check("done_err", {31'd0, err}, {31'd0, e.err});
        end
      end
    end
  end

  // Slot arbiter + RAM model: grants each REQ episode after its queued delay,
  // returns q one cycle after a read grant, drives noise otherwise.
  initial begin
    bit lvl, prev_lvl, pend;
    int wait_cnt, cur_delay;
    logic [7:0] paddr;
    prev_lvl = 0; pend = 0; wait_cnt = 0; cur_delay = 0; paddr = '0;
    forever begin
      @(negedge CLK);
      if (rst) begin
        pend = 0;
        prev_lvl = 0;
        mem_acq = 1'b0;
      end else begin
        if (pend) begin
          mem_dq = ram[paddr];
          pend = 0;
        end else begin
          mem_dq = 8'($urandom);
        end
        lvl = mem_rden | mem_wren;
        if (lvl && !prev_lvl) begin
          cur_delay = (delay_q.size() != 0) ? delay_q.pop_front() : 0;
          wait_cnt = 0;
        end
        prev_lvl = lvl;
        if (lvl) begin
          if (wait_cnt == cur_delay) begin
            mem_acq = 1'b1;
            grant_q.push_back('{mem_wren, mem_addr, mem_din});
            if (mem_wren) ram[mem_addr] = mem_din;
            else begin
              pend = 1;
              paddr = mem_addr;
            end
          end else begin
            mem_acq = 1'b0;
          end
          wait_cnt++;
        end else begin
          mem_acq = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!req_ready && k < 400) begin
      @(posedge CLK); #1;
      k++;
    end
    if (k >= 400) fail("wait_ready_timeout");
  endtask

  task automatic wait_done();
    int k = 0;
    while ((exp_q.size() != 0 || !req_ready) && k < 400) begin
      @(posedge CLK); #1;
      k++;
    end
    if (k >= 400) fail("wait_done_timeout");
  endtask

  // Reference model: computes the expected events from the request and the grant
  // delays it hands to the slot model, then drives the request.
  task automatic run_req(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [3:0] len, input int forced, input bit poke);
    int n, d;
    logic [7:0] a;
    bit aborted;
    wait_ready();
    n = (wr || len == 4'd0) ? 1 : int'(len);
    a = addr;
    aborted = 0;
    for (int i = 0; i < n; i++) begin
      d = (forced >= 0) ? forced : rand_delay();
      delay_q.push_back(d);
      if (d >= TO) begin
        exp_q.push_back('{1'b1, 8'h00, 1'b1});
        aborted = 1;
        break;
      end
      if (wr) ram_m[a] = wdata;
      else exp_q.push_back('{1'b0, ram_m[a], 1'b0});
      a = a + 8'd1;
    end
    if (!aborted) exp_q.push_back('{1'b1, 8'h00, 1'b0});
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_len   = len;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    if (poke) begin
      req_valid = 1'b1;
      req_write = 1'($urandom);
      req_addr  = 8'($urandom);
      req_len   = 4'($urandom);
      @(posedge CLK); #1;
      req_valid = 1'b0;
    end
  endtask

  initial begin
    int b_rden, b_wren, b_rdv, b_done, b_grant;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'($urandom);
      ram_m[i] = ram[i];
    end
    rst = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rden_wren", {30'd0, mem_rden, mem_wren}, 32'd0);
    check("rst_pulses", {29'd0, rd_valid, done, err}, 32'd0);
    check("rst_addr_din_rdata", {8'd0, mem_addr, mem_din, rd_data}, 32'd0);
    rst = 1'b0;

    // 1: single read, grant in the third REQ cycle.
    ram[8'h10] = 8'hA5; ram_m[8'h10] = 8'hA5;
    b_rden = rden_cycles; b_rdv = rdv_cnt; b_grant = grant_q.size();
    run_req(1'b0, 8'h10, 8'h00, 4'd1, 2, 1'b0);
    wait_done();
    check("t1_rden_cycles", rden_cycles - b_rden, 3);
    check("t1_rdv_count", rdv_cnt - b_rdv, 1);
    check("t1_done_after_rdv", last_done_cyc - last_rdv_cyc, 1);
    check("t1_grants", grant_q.size() - b_grant, 1);
    if (grant_q.size() > b_grant) check("t1_addr", {24'd0, grant_q[b_grant].addr}, 32'h10);

    // 2: single write, immediate grant; read it back afterwards.
    b_wren = wren_cycles; b_rdv = rdv_cnt; b_grant = grant_q.size();
    run_req(1'b1, 8'h20, 8'h3C, 4'd7, 0, 1'b0);
    wait_done();
    check("t2_wren_cycles", wren_cycles - b_wren, 1);
    check("t2_no_rdv", rdv_cnt - b_rdv, 0);
    check("t2_grants", grant_q.size() - b_grant, 1);
    if (grant_q.size() > b_grant) begin
      check("t2_addr", {24'd0, grant_q[b_grant].addr}, 32'h20);
      check("t2_din", {24'd0, grant_q[b_grant].din}, 32'h3C);
      check("t2_is_write", {31'd0, grant_q[b_grant].wr}, 32'd1);
    end
    run_req(1'b0, 8'h20, 8'h00, 4'd1, 1, 1'b0);
    wait_done();

    // 3: burst across the address wrap.
    for (int i = 0; i < 3; i++) begin
      logic [7:0] ad;
      ad = 8'hFE + 8'(i);
      ram[ad] = ad ^ 8'hFF;
      ram_m[ad] = ad ^ 8'hFF;
    end
    b_rdv = rdv_cnt; b_done = done_cnt; b_grant = grant_q.size();
    run_req(1'b0, 8'hFE, 8'h00, 4'd3, 0, 1'b0);
    wait_done();
    check("t3_rdv_count", rdv_cnt - b_rdv, 3);
    check("t3_done_count", done_cnt - b_done, 1);
    check("t3_grants", grant_q.size() - b_grant, 3);
    if (grant_q.size() >= b_grant + 3) begin
      check("t3_addr0", {24'd0, grant_q[b_grant].addr}, 32'hFE);
      check("t3_addr1", {24'd0, grant_q[b_grant + 1].addr}, 32'hFF);
      check("t3_addr2", {24'd0, grant_q[b_grant + 2].addr}, 32'h00);
    end

    // 4: grant never comes -> timeout.
    b_rden = rden_cycles; b_rdv = rdv_cnt; b_done = done_cnt;
    run_req(1'b0, 8'h40, 8'h00, 4'd2, 6, 1'b0);
    wait_done();
    check("t4_rden_cycles", rden_cycles - b_rden, TO);
    check("t4_no_rdv", rdv_cnt - b_rdv, 0);
    check("t4_done_count", done_cnt - b_done, 1);
    check("t4_ready", {31'd0, req_ready}, 32'd1);

    // 6: length 0 means one word; a req_valid while busy is ignored.
    b_rden = rden_cycles; b_rdv = rdv_cnt; b_done = done_cnt;
    run_req(1'b0, 8'h50, 8'h00, 4'd0, 0, 1'b1);
    wait_done();
    repeat (4) @(posedge CLK);
    #1;
    check("t6_rden_cycles", rden_cycles - b_rden, 1);
    check("t6_rdv_count", rdv_cnt - b_rdv, 1);
    check("t6_done_count", done_cnt - b_done, 1);

    // 5: reset in the middle of a burst.
    b_rdv = rdv_cnt;
    run_req(1'b0, 8'h60, 8'h00, 4'd4, 0, 1'b0);
    begin
      int k = 0;
      while (rdv_cnt == b_rdv && k < 100) begin
        @(negedge CLK);
        k++;
      end
      if (k >= 100) fail("t5_rdv_timeout");
    end
    rst = 1'b1;
    @(posedge CLK); #1;
    exp_q.delete();
    delay_q.delete();
    check("t5_ready", {31'd0, req_ready}, 32'd1);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_rden_wren", {30'd0, mem_rden, mem_wren}, 32'd0);
    check("t5_pulses", {29'd0, rd_valid, done, err}, 32'd0);
    check("t5_addr_rdata", {16'd0, mem_addr, rd_data}, 32'd0);
    rst = 1'b0;
    b_done = done_cnt;
    repeat (6) @(posedge CLK);
    #1;
    check("t5_no_done", done_cnt - b_done, 0);
    run_req(1'b0, 8'h61, 8'h00, 4'd1, 1, 1'b0);
    wait_done();
    check("t5_fresh_done", done_cnt - b_done, 1);

    // Randomized traffic in a window that crosses the address wrap.
    for (int r = 0; r < 150; r++) begin
      run_req(($urandom_range(0, 3) == 0), 8'hF8 + 8'($urandom_range(0, 15)),
              8'($urandom), 4'($urandom_range(0, 6)), -1, ($urandom_range(0, 3) == 0));
    end
    wait_done();
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

endmodule
